// File: rtl/h75_pkg.sv
// rtl/h75_pkg.sv - shared constants, swap FSM states and plane-bit helper for the HUB75 plane reader
package h75_pkg;

    localparam int ADDR_W = 14;
    localparam int RAM_W  = 48;
    localparam int HALF_W = 24;

    localparam int TOP_B = 0;
    localparam int TOP_G = 8;
    localparam int TOP_R = 16;
    localparam int BOT_B = 24;
    localparam int BOT_G = 32;
    localparam int BOT_R = 40;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } swap_state_t;

    // Picks bit p of each colour byte of one RGB888 half-word; offsets are relative to the half.
    function automatic logic [2:0] plane_bits(input logic [HALF_W-1:0] px, input logic [2:0] p);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = px[TOP_R - TOP_B +: 8];
        g = px[TOP_G - TOP_B +: 8];
        b = px[0 +: 8];
        return {r[p], g[p], b[p]};
    endfunction

endpackage

// File: rtl/h75_plane_reader_if.sv
// rtl/h75_plane_reader_if.sv - frame RAM read port between the plane reader and the RAM
interface h75_plane_reader_if #(
    parameter int ADDR_W = 14
) ();

    logic [ADDR_W:0] ram_addr;
    logic            ram_rd;
    logic [47:0]     ram_rdata;

    modport master (
        output ram_addr,
        output ram_rd,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr,
        input  ram_rd,
        output ram_rdata
    );

endinterface

// File: rtl/h75_pipe_delay.sv
// rtl/h75_pipe_delay.sv - fixed-depth shift register with synchronous clear
module h75_pipe_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/h75_plane_reader.sv
// rtl/h75_plane_reader.sv - double-buffered RGB888 fetch and bit-plane extraction with frame-synchronous swap
module h75_plane_reader #(
    parameter int RAM_LATENCY = 2,
    parameter int ADDR_W      = h75_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_sync,
    input  logic [2:0]                plane,
    input  logic [ADDR_W-1:0]         rd_addr,
    input  logic                      rd_req,
    input  logic                      swap_req,
    output logic                      swap_ack,
    output logic                      disp_bank,
    h75_plane_reader_if.master        ram,
    output logic [2:0]                rgb_top,
    output logic [2:0]                rgb_bot,
    output logic                      rgb_valid,
    output logic [15:0]               frame_count
);

    import h75_pkg::*;

    localparam int PIPE_DEPTH = RAM_LATENCY + 1;

    swap_state_t state_q;
    swap_state_t state_d;
    logic        fs_q;
    logic        fs_rise;
    logic        do_swap;
    logic [3:0]  dl_out;
    logic        dl_valid;
    logic [2:0]  dl_plane;

    assign fs_rise = frame_sync & ~fs_q;

    // A request seen together with an edge while idle swaps at that same edge.
    always_comb begin
        state_d = state_q;
        do_swap = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (swap_req) begin
                    if (fs_rise) begin
                        do_swap = 1'b1;
                    end else begin
                        state_d = S_PEND;
                    end
                end
            end
            S_PEND: begin
                if (fs_rise) begin
                    do_swap = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fs_q        <= 1'b0;
            disp_bank   <= 1'b0;
            swap_ack    <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q   <= state_d;
            fs_q      <= frame_sync;
            disp_bank <= disp_bank ^ do_swap;
            swap_ack  <= do_swap;
            if (fs_rise) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Bank is captured here, so fetches already issued finish from the old buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram.ram_addr <= '0;
            ram.ram_rd   <= 1'b0;
        end else begin
            ram.ram_rd <= rd_req;
            if (rd_req) begin
                ram.ram_addr <= {disp_bank, rd_addr};
            end
        end
    end

    h75_pipe_delay #(
        .DEPTH (PIPE_DEPTH),
        .WIDTH (4)
    ) u_plane_delay (
        .clk  (clk),
        .clr  (reset),
        .din  ({rd_req, plane}),
        .dout (dl_out)
    );

    assign dl_valid = dl_out[3];
    assign dl_plane = dl_out[2:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_valid <= 1'b0;
            rgb_top   <= '0;
            rgb_bot   <= '0;
        end else begin
            rgb_valid <= dl_valid;
            if (dl_valid) begin
                rgb_top <= plane_bits(ram.ram_rdata[TOP_B +: HALF_W], dl_plane);
                rgb_bot <= plane_bits(ram.ram_rdata[BOT_B +: HALF_W], dl_plane);
            end else begin
                rgb_top <= '0;
                rgb_bot <= '0;
            end
        end
    end

endmodule

// File: doc/h75_plane_reader.md
# h75_plane_reader

Pixel fetch and bit-plane extraction stage for the HUB75 CAPE. It sits directly downstream of the HUB75 timing generator and consumes that block's per-pixel read address, current bit plane and frame sync. It reads a double-buffered RGB888 frame RAM and outputs the selected bit of each colour for the upper and lower half-panel rows, aligned with a valid strobe. It also owns the front/back buffer swap handshake with the host.

## Interface
- `RAM_LATENCY`, 2: RAM read latency in cycles, from `ram_rd` to `ram_rdata`; legal range 1..4.
- `ADDR_W`, 14: pixel address width, {y[4:0], x[8:0]}.
- `clk` in 1: system clock.
- `reset` in 1: synchronous reset, active-high. One clock; reset is synchronous and active-high.
- `frame_sync` in 1: frame start from the timing generator; the rising edge is the frame boundary.
- `plane` in 3: bit plane (0..7) to extract; sampled together with `rd_req`.
- `rd_addr` in ADDR_W: pixel address; valid when `rd_req`=1.
- `rd_req` in 1: one pixel-pair fetch request per high cycle; back-to-back requests allowed.
- `swap_req` in 1: host pulse requesting a buffer swap.
- `swap_ack` out 1: one-cycle pulse when the swap takes effect.
- `disp_bank` out 1: bank currently being displayed.
- `ram_addr` out ADDR_W+1: {bank, rd_addr}.
- `ram_rd` out 1: RAM read strobe.
- `ram_rdata` in 48: {bottom R,G,B[23:0], top R,G,B[23:0]}, 8 bits per channel, R in the MSBs.
- `rgb_top` out 3: {R,G,B} plane bit for the upper row (R1 G1 B1).
- `rgb_bot` out 3: {R,G,B} plane bit for the lower row (R2 G2 B2).
- `rgb_valid` out 1: `rgb_top` and `rgb_bot` are valid.
- `frame_count` out 16: count of frame_sync rising edges; wraps.

## Operation
- **Fetch:** a request with `rd_req`=1 at cycle T registers `ram_addr` = {disp_bank@T, rd_addr@T} and `ram_rd`=1 at T+1. `ram_rd` is 0 whenever no request was made at T.
- **Alignment:** `plane` and the request valid bit ride a delay line matched to RAM_LATENCY+1 stages, so `plane` may change between requests without corrupting data in flight.
- **Bit extraction:** each output bit = channel[p], where p is the delayed plane.
  - rgb_top = {rdata[16+p], rdata[8+p], rdata[p]}
  - rgb_bot = {rdata[40+p], rdata[32+p], rdata[24+p]}
- **Frame sync edge:** a rising edge is detected against a registered copy of `frame_sync`. On each edge, `frame_count` increments (0xFFFF→0).
- **Swap FSM, two states:**
  - S_IDLE: `swap_req`=1 → S_PEND.
  - S_PEND: on a frame_sync rising edge, toggle `disp_bank`, pulse `swap_ack` on the next cycle, then → S_IDLE. Further `swap_req` pulses while in S_PEND are absorbed; one swap results.
- **Simultaneous events:**
  - `swap_req` in S_IDLE in the same cycle as a rising edge: the swap is applied at that edge.
  - `swap_req` in the same cycle as `swap_ack`: starts a new pending request.
- **Bank binding:** the bank is bound at request time. Requests already in flight when `disp_bank` toggles complete from the old bank.
- **Reset:** every output is 0, `disp_bank`=0, FSM = S_IDLE, delay line cleared.
  - Reset mid-fetch drops all in-flight data; `rgb_valid` is 0 from the cycle after reset is sampled.
  - No stale `rgb_valid` appears after reset is released.

## Timing
- Request at T → `ram_rd` at T+1 → `ram_rdata` at T+1+RAM_LATENCY → `rgb_*`/`rgb_valid` registered at T+2+RAM_LATENCY. This is 4 cycles at the default latency.
- Throughput: one pixel pair per clock, with no stalls.
- frame_sync rise sampled at cycle F (the swap FSM in S_PEND, or in S_IDLE with `swap_req`=1 at F):
  - `disp_bank` toggles at F+1;
  - `swap_ack`=1 at F+1 for exactly one cycle;
  - `frame_count` updates at F+1.
- Requests at cycle ≥ F+1 use the new bank.
- `frame_sync` held high does not retrigger; only the rising edge counts.

## Structure
- Shared package `h75_pkg`:
  - RAM word field offsets (TOP_R/G/B, BOT_R/G/B);
  - ADDR_W;
  - the swap FSM state enum.
- Sub-module `h75_pipe_delay`: parametrised depth/width shift register with synchronous clear. It carries {valid, plane} through the RAM latency.

## Test plan
- **Single fetch:** reset, then one `rd_req` with rd_addr=0x0041, plane=7, RAM top=0x80_00_FF, bottom=0x00_80_00. Required: `ram_addr`=0x00041 at T+1; at T+4 `rgb_top`=3'b101, `rgb_bot`=3'b010, `rgb_valid`=1 for one cycle.
- **Streaming with plane change:** 512 back-to-back requests, plane switching 7→2 mid-stream, RAM model data = address pattern. Required: 512 contiguous valid outputs, each using the plane sampled with its own request.
- **Swap:** `swap_req` pulse, then frame_sync rises 100 cycles later. Required: `disp_bank` 0→1 and `swap_ack` pulse at edge+1; `ram_addr[14]`=1 for subsequent requests, while in-flight requests keep bank 0.
- **Coalesce and simultaneity:** three `swap_req` pulses before one edge → exactly one toggle. Then `swap_req` coincident with an edge in S_IDLE → toggle at that edge.
- **Reset mid-stream:** assert `reset` for 1 cycle while 3 fetches are in flight. Required: `rgb_valid`=0 for the following 4 cycles, all outputs 0, `frame_count`=0.
- **Latency sweep:** repeat the single-fetch case for RAM_LATENCY=1 and 4. Required: output appears at T+3 and T+6 respectively.
